init_delay_feeder: RTL and testbench

Upstream feeder for the WIDTH-bit registered data stage. After reset it drives the constant INIT word for INIT_DELAY cycles (init phase). It then forwards words from a valid/ready source through a 2-entry buffer. out_data always carries a defined value (INIT or the last buffered word), so the downstream register never samples X.

---
 rtl/init_delay_feeder_pkg.sv | 17 +
 rtl/feeder_skid2.sv | 66 ++++++
 rtl/init_delay_feeder.sv | 75 +++++++
 tb/tb_init_delay_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/init_delay_feeder_pkg.sv
// Shared types and helpers for the init_delay_feeder block.
package init_delay_feeder_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int BUF_DEPTH = 2;

    function automatic int cnt_width(input int init_delay);
        int w;
        w = $clog2(init_delay + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/feeder_skid2.sv
// Two-entry valid/ready buffer; out_data is the head entry, or the last
// popped word (RESET_VAL before any word) while the buffer is empty.
import init_delay_feeder_pkg::*;

module feeder_skid2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic             READY_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run_next,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    // Valid/ready: a word moves when valid and ready are both high at a rising
    // edge; valid never depends on ready, and ready is a registered flag.
    logic [1:0]       occ;
    logic [1:0]       occ_n;
    logic [WIDTH-1:0] tail;
    logic             push;
    logic             pop;

    always_comb begin
        push  = in_valid && in_ready;
        pop   = out_valid && out_ready;
        occ_n = occ;
        if (push && !pop) begin
            occ_n = occ + 2'd1;
        end else if (!push && pop) begin
            occ_n = occ - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ       <= 2'd0;
            out_data  <= RESET_VAL;
            tail      <= RESET_VAL;
            out_valid <= 1'b0;
            in_ready  <= READY_RST;
        end else begin
            assert (!(push && occ == FULL));
            occ       <= occ_n;
            out_valid <= (occ_n != 2'd0);
            in_ready  <= run_next && (occ_n != FULL);
            // Head is only replaced by a shift or a new word; a pop to empty keeps it.
            if (pop && occ == FULL) begin
                out_data <= tail;
            end else if (push && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                out_data <= in_data;
            end
            if (push && occ == 2'd1 && !pop) begin
                tail <= in_data;
            end
        end
    end

endmodule

// File: rtl/init_delay_feeder.sv
// Drives INIT for INIT_DELAY cycles after reset, then forwards source words
// through a 2-entry buffer so the downstream register never samples X.
import init_delay_feeder_pkg::*;

module init_delay_feeder #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] INIT       = '0,
    parameter int               INIT_DELAY = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             init_done,
    output logic             dbg_state
);

    localparam int             CW   = cnt_width(INIT_DELAY);
    localparam logic [CW-1:0]  LAST = CW'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
    localparam logic           NO_INIT = (INIT_DELAY == 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          run_next;

    assign dbg_state = state;

    // Buffer ready for the next cycle must already reflect the state after this edge.
    always_comb begin
        run_next = (state == ST_RUN) || (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= NO_INIT ? ST_RUN : ST_INIT;
            cnt       <= '0;
            init_done <= NO_INIT;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    feeder_skid2 #(
        .WIDTH     (WIDTH),
        .RESET_VAL (INIT),
        .READY_RST (NO_INIT)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .run_next  (run_next),
        .in_data   (in_data),
        .in_valid  (in_valid && (state == ST_RUN)),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_init_delay_feeder.sv
// Bench for init_delay_feeder: directed and random steps against a queue model.
module tb_init_delay_feeder;

    localparam int         DELAY = 2;
    localparam logic [3:0] INITV = 4'hA;
    localparam logic [3:0] INIT0 = 4'h5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       init_done;
    logic       dbg_state;

    logic [3:0] in_data0 = '0;
    logic       in_valid0 = 1'b0;
    logic       in_ready0;
    logic [3:0] out_data0;
    logic       out_valid0;
    logic       init_done0;
    logic       dbg_state0;

    int checks = 0;
    int failures = 0;

    // Reference model: queue contents, last word handed downstream, edges since release.
    logic [3:0] exp_q[$];
    logic [3:0] m_last;
    int         m_edges;

    always #5 clk = ~clk;

    init_delay_feeder #(.WIDTH(4), .INIT(INITV), .INIT_DELAY(DELAY)) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .init_done(init_done), .dbg_state(dbg_state)
    );

    init_delay_feeder #(.WIDTH(4), .INIT(INIT0), .INIT_DELAY(0)) dut0 (
        .clk(clk), .rstn(rstn), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(1'b0), .init_done(init_done0), .dbg_state(dbg_state0)
    );

    function automatic logic m_run();
        return m_edges >= DELAY;
    endfunction

    function automatic logic m_ready();
        return m_run() && (exp_q.size() < 2);
    endfunction

    function automatic logic m_valid();
        return exp_q.size() > 0;
    endfunction

    function automatic logic [3:0] m_data();
        return (exp_q.size() > 0) ? exp_q[0] : m_last;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_data"}, 32'(out_data), 32'(m_data()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid()));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
        chk({tag, ".init_done"}, 32'(init_done), 32'(m_run()));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last  = INITV;
        m_edges = 0;
    endtask

    // One clock: drive at negedge, model the edge, check #1 after it.
    task automatic cycle(input logic v, input logic [3:0] d, input logic r, input string tag);
        logic push;
        logic pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        push = v && m_ready();
        pop  = m_valid() && r;
        @(posedge clk);
        #1;
        if (pop) m_last = exp_q.pop_front();
        if (push) exp_q.push_back(d);
        m_edges++;
        chk_all(tag);
        @(negedge clk);
    endtask

    initial begin
        logic       sv;
        logic [3:0] sd;
        model_reset();
        in_valid0 = 1'b1;
        in_data0  = 4'h9;
        repeat (2) @(negedge clk);

        // Reset state of both builds.
        chk_all("rst");
        chk("rst0.in_ready", 32'(in_ready0), 32'd1);
        chk("rst0.init_done", 32'(init_done0), 32'd1);
        chk("rst0.out_data", 32'(out_data0), 32'(INIT0));
        chk("rst0.out_valid", 32'(out_valid0), 32'd0);

        // Init phase; inputs offered during it must be ignored.
        rstn = 1'b1;
        cycle(1'b1, 4'hE, 1'b1, "init1");
        chk("zero_delay.out_valid", 32'(out_valid0), 32'd1);
        chk("zero_delay.out_data", 32'(out_data0), 32'h9);
        in_valid0 = 1'b0;
        cycle(1'b1, 4'hE, 1'b1, "init2");

        // Single transfer.
        cycle(1'b1, 4'h3, 1'b1, "single_push");
        chk("single.data", 32'(out_data), 32'h3);
        cycle(1'b0, 4'h0, 1'b1, "single_pop");
        chk("single.hold", 32'(out_data), 32'h3);

        // Back-pressure then drain.
        cycle(1'b1, 4'h5, 1'b0, "bp_push5");
        cycle(1'b1, 4'h6, 1'b0, "bp_push6");
        chk("bp.full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 4'h7, 1'b0, "bp_hold7");
        cycle(1'b1, 4'h7, 1'b1, "bp_drain5");
        cycle(1'b1, 4'h7, 1'b1, "bp_drain6");
        cycle(1'b0, 4'h0, 1'b1, "bp_drain7");
        cycle(1'b0, 4'h0, 1'b1, "bp_empty");

        // Streaming one word per cycle.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 4'(i), 1'b1, "stream");
            chk("stream.word", 32'(out_data), 32'(i));
            chk("stream.ready", 32'(in_ready), 32'd1);
        end
        cycle(1'b0, 4'h0, 1'b1, "stream_tail");

        // Random traffic; the source holds its word until accepted.
        sv = 1'b0;
        sd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!sv || in_ready) begin
                sv = ($urandom_range(0, 3) != 0);
                sd = 4'($urandom_range(0, 15));
            end
            cycle(sv, sd, ($urandom_range(0, 2) != 0), "rand");
        end

        // Mid-run asynchronous reset with two entries buffered.
        cycle(1'b0, 4'h0, 1'b1, "pre_fill");
        cycle(1'b1, 4'hB, 1'b0, "fill1");
        cycle(1'b1, 4'hC, 1'b0, "fill2");
        chk("fill.valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        chk("async_rst.out_data", 32'(out_data), 32'(INITV));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 4'h1, 1'b1, "reinit1");
        chk("reinit1.done", 32'(init_done), 32'd0);
        cycle(1'b1, 4'h1, 1'b1, "reinit2");
        chk("reinit2.done", 32'(init_done), 32'd1);
        cycle(1'b1, 4'h2, 1'b1, "reinit_push");
        cycle(1'b0, 4'h0, 1'b1, "reinit_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
